// File: rtl/phase_scheduler.sv
// Three-phase frame sequencer (input -> action -> display) with per-phase bypass,
// a per-phase watchdog, a sticky timeout error and a completed-frame counter.
module phase_scheduler #(
    parameter int unsigned TO_CYC = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       step_i,
    input  logic [2:0] cfg_skip_i,
    input  logic [2:0] done_i,
    input  logic       err_clr_i,
    output logic [2:0] en_o,
    output logic [1:0] ph_o,
    output logic       busy_o,
    output logic       frame_o,
    output logic [7:0] frame_cnt_o,
    output logic       err_o,
    output logic [1:0] err_ph_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ADV   = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    state_t     state_q, state_d;
    logic [1:0] ph_q, ph_d;
    logic [2:0] en_q, en_d;
    logic [7:0] timer_q, timer_d;
    logic       frame_q, frame_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [1:0] err_ph_q, err_ph_d;

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        en_d     = en_q;
        timer_d  = timer_q;
        frame_d  = 1'b0;
        cnt_d    = cnt_q;
        err_d    = err_q;
        err_ph_d = err_ph_q;

        // Clear first so a timeout later in this cycle takes precedence.
        if (err_clr_i) err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                en_d = 3'b000;
                if (run_i || step_i) begin
                    state_d = S_ISSUE;
                    ph_d    = 2'd0;
                end
            end
            S_ISSUE: begin
                if (cfg_skip_i[ph_q]) begin
                    en_d    = 3'b000;
                    state_d = S_ADV;
                end else begin
                    en_d    = 3'b001 << ph_q;
                    timer_d = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // done on the watchdog edge counts as success
                if (done_i[ph_q]) begin
                    en_d    = 3'b000;
                    state_d = S_ADV;
                end else if (timer_q == TO_LAST) begin
                    en_d     = 3'b000;
                    err_d    = 1'b1;
                    err_ph_d = ph_q;
                    state_d  = S_ADV;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_ADV: begin
                if (ph_q == 2'd2) begin
                    frame_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    ph_d    = 2'd0;
                    state_d = run_i ? S_ISSUE : S_IDLE;
                end else begin
                    ph_d    = ph_q + 2'd1;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ph_q     <= 2'd0;
            en_q     <= 3'b000;
            timer_q  <= 8'd0;
            frame_q  <= 1'b0;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            err_ph_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            en_q     <= en_d;
            timer_q  <= timer_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_ph_q <= err_ph_d;
        end
    end

    assign en_o        = en_q;
    assign ph_o        = ph_q;
    assign busy_o      = (state_q != S_IDLE);
    assign frame_o     = frame_q;
    assign frame_cnt_o = cnt_q;
    assign err_o       = err_q;
    assign err_ph_o    = err_ph_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler with TO_CYC=8: full frame, timeout, skip,
// done-vs-timeout corner, reset mid-WAIT, counter wrap and single step.
module tb_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_i, run_i, step_i, err_clr_i;
    logic [2:0] cfg_skip_i, done_i;
    logic [2:0] en_o;
    logic [1:0] ph_o, err_ph_o;
    logic       busy_o, frame_o, err_o;
    logic [7:0] frame_cnt_o;

    int n_chk = 0;
    int n_bad = 0;

    phase_scheduler #(.TO_CYC(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .run_i       (run_i),
        .step_i      (step_i),
        .cfg_skip_i  (cfg_skip_i),
        .done_i      (done_i),
        .err_clr_i   (err_clr_i),
        .en_o        (en_o),
        .ph_o        (ph_o),
        .busy_o      (busy_o),
        .frame_o     (frame_o),
        .frame_cnt_o (frame_cnt_o),
        .err_o       (err_o),
        .err_ph_o    (err_ph_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for en_o[k] to rise; the check fails if the bound expires.
    task automatic wait_en(input int k, input string tag);
        int n;
        n = 0;
        while (!en_o[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rise"}, {31'd0, en_o[k]}, 32'd1);
    endtask

    // Called on the negedge right after en_o[k] rose; done is sampled dly edges later.
    task automatic done_after(input int k, input int dly);
        repeat (dly - 1) @(negedge clk);
        done_i[k] = 1'b1;
        @(negedge clk);
        done_i = 3'b000;
    endtask

    task automatic step_pulse();
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
    endtask

    initial begin
        int hi, n, frames;
        logic saw1;
        logic [2:0] exp_en;
        rst_i = 1'b1; run_i = 1'b0; step_i = 1'b0; err_clr_i = 1'b0;
        cfg_skip_i = 3'b000; done_i = 3'b000;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_en",   {29'd0, en_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_cnt",  {24'd0, frame_cnt_o}, 32'd0);
        chk("rst_err",  {31'd0, err_o}, 32'd0);

        // Full frame under run, run dropped mid-frame
        run_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_en(k, "full");
            exp_en = 3'b001 << k;
            chk("full_en", {29'd0, en_o}, {29'd0, exp_en});
            chk("full_ph", {30'd0, ph_o}, k);
            if (k == 2) run_i = 1'b0;
            done_after(k, 3);
            chk("full_en_off", {29'd0, en_o}, 32'd0);
        end
        chk("full_frame_early", {31'd0, frame_o}, 32'd0);
        @(negedge clk);
        chk("full_frame", {31'd0, frame_o}, 32'd1);
        chk("full_cnt",   {24'd0, frame_cnt_o}, 32'd1);
        chk("full_idle",  {31'd0, busy_o}, 32'd0);
        chk("full_err",   {31'd0, err_o}, 32'd0);
        @(negedge clk);
        chk("full_frame_1cyc", {31'd0, frame_o}, 32'd0);

        // Watchdog on the action phase
        step_pulse();
        wait_en(0, "to0");
        done_after(0, 3);
        wait_en(1, "to1");
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_o[1]) hi++;
            else break;
        end
        chk("to_hi_cycles", hi, 32'd8);
        chk("to_err",    {31'd0, err_o}, 32'd1);
        chk("to_err_ph", {30'd0, err_ph_o}, 32'd1);
        wait_en(2, "to2");
        done_after(2, 3);
        @(negedge clk);
        chk("to_frame", {31'd0, frame_o}, 32'd1);
        chk("to_cnt",   {24'd0, frame_cnt_o}, 32'd2);
        chk("to_idle",  {31'd0, busy_o}, 32'd0);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        chk("clr_err",    {31'd0, err_o}, 32'd0);
        chk("clr_err_ph", {30'd0, err_ph_o}, 32'd1);

        // Bypass the action phase
        cfg_skip_i = 3'b010;
        step_pulse();
        wait_en(0, "sk0");
        done_after(0, 3);
        n = 0; saw1 = 1'b0;
        while (!en_o[2] && n < 20) begin
            @(negedge clk);
            n++;
            if (en_o[1]) saw1 = 1'b1;
        end
        chk("skip_gap", n, 32'd4);
        chk("skip_en1", {31'd0, saw1}, 32'd0);
        done_after(2, 3);
        @(negedge clk);
        chk("skip_frame", {31'd0, frame_o}, 32'd1);
        chk("skip_cnt",   {24'd0, frame_cnt_o}, 32'd3);
        cfg_skip_i = 3'b000;

        // done on the timeout edge, clear vs timeout, reset mid-WAIT
        step_pulse();
        wait_en(0, "cr0");
        done_after(0, 8);
        chk("corner_en",  {29'd0, en_o}, 32'd0);
        chk("corner_err", {31'd0, err_o}, 32'd0);
        wait_en(1, "cr1");
        repeat (7) @(negedge clk);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        chk("clrwin_en",     {29'd0, en_o}, 32'd0);
        chk("clrwin_err",    {31'd0, err_o}, 32'd1);
        chk("clrwin_err_ph", {30'd0, err_ph_o}, 32'd1);
        wait_en(2, "cr2");
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("mrst_en",     {29'd0, en_o}, 32'd0);
        chk("mrst_ph",     {30'd0, ph_o}, 32'd0);
        chk("mrst_busy",   {31'd0, busy_o}, 32'd0);
        chk("mrst_err",    {31'd0, err_o}, 32'd0);
        chk("mrst_err_ph", {30'd0, err_ph_o}, 32'd0);
        chk("mrst_cnt",    {24'd0, frame_cnt_o}, 32'd0);
        done_i = 3'b100;
        @(negedge clk);
        done_i = 3'b000;
        @(negedge clk);
        chk("stray_busy",  {31'd0, busy_o}, 32'd0);
        chk("stray_frame", {31'd0, frame_o}, 32'd0);
        chk("stray_cnt",   {24'd0, frame_cnt_o}, 32'd0);

        // 256 all-bypassed frames wrap the counter
        cfg_skip_i = 3'b111;
        run_i = 1'b1;
        frames = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            chk("wrap_en", {29'd0, en_o}, 32'd0);
            if (frame_o) begin
                frames++;
                if (frames == 255) begin
                    chk("wrap_cnt255", {24'd0, frame_cnt_o}, 32'd255);
                    run_i = 1'b0;
                end
                if (frames == 256) break;
            end
        end
        chk("wrap_frames", frames, 32'd256);
        chk("wrap_cnt",    {24'd0, frame_cnt_o}, 32'd0);
        chk("wrap_idle",   {31'd0, busy_o}, 32'd0);

        // Single step yields exactly one frame
        step_pulse();
        frames = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_o) frames++;
        end
        chk("step_frames", frames, 32'd1);
        chk("step_cnt",    {24'd0, frame_cnt_o}, 32'd1);
        chk("step_idle",   {31'd0, busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 SHALL have parameter TO_CYC, default 255, meaning the watchdog limit in cycles a phase may hold its enable without done (legal 2..255).
REQ-002 SHALL have port clk_i  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port run_i  input  1  level; free-running frame sequencing while high.
REQ-005 SHALL have port step_i  input  1  single-cycle pulse; run exactly one frame from IDLE.
REQ-006 SHALL have port cfg_skip_i  input  3  per-phase bypass: bit0 input, bit1 action, bit2 display.
REQ-007 SHALL have port done_i  input  3  per-phase done from input/action/display stages.
REQ-008 SHALL have port err_clr_i  input  1  pulse; clears the sticky error.
REQ-009 SHALL have port en_o  output  3  per-phase enable, one-hot or zero, registered.
REQ-010 SHALL have port ph_o  output  2  current phase index 0..2.
REQ-011 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port frame_o  output  1  one-cycle pulse on frame completion.
REQ-013 SHALL have port frame_cnt_o  output  8  completed-frame counter.
REQ-014 SHALL have port err_o  output  1  sticky watchdog error.
REQ-015 SHALL have port err_ph_o  output  2  phase index of the most recent timeout.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, ADV; every output registered.
REQ-017 IDLE: on an edge with run_i or step_i high SHALL go to ISSUE with ph=0; otherwise stay, en_o=0.
REQ-018 ISSUE, cfg_skip_i[ph]=0: SHALL set en_o[ph]=1, clear timer to 0, go to WAIT (en_o rises 2 edges after run_i/step_i is sampled).
REQ-019 ISSUE, cfg_skip_i[ph]=1: SHALL go to ADV with en_o held 0; skip is sampled only in ISSUE.
REQ-020 WAIT, done_i[ph]=1: SHALL clear en_o[ph] and go to ADV on that edge.
REQ-021 WAIT, no done, timer==TO_CYC-1: SHALL clear en_o, set err_o=1, err_ph_o=ph, go to ADV; en_o[ph] is therefore high exactly TO_CYC cycles.
REQ-022 WAIT, otherwise: SHALL increment the timer (8-bit, no wrap possible within legal TO_CYC).
REQ-023 done_i and timeout on the same edge: done SHALL win, no error.
REQ-024 done_i bits for inactive phases, and all done_i outside WAIT, SHALL be ignored.
REQ-025 ADV, ph<2: SHALL set ph=ph+1 and go to ISSUE.
REQ-026 ADV, ph==2: SHALL pulse frame_o for one cycle, increment frame_cnt_o mod 256 (255->0), set ph=0, go to ISSUE if run_i high, else IDLE.
REQ-027 run_i falling mid-frame SHALL NOT abort; the frame completes, then IDLE.
REQ-028 step_i outside IDLE SHALL be ignored; step_i from IDLE with run_i low SHALL yield exactly one frame.
REQ-029 cfg_skip_i=3'b111 SHALL still complete frames (ISSUE/ADV per phase, 6 cycles per frame, no enables).
REQ-030 err_clr_i SHALL clear err_o; a timeout on the same edge SHALL win (err_o stays 1).

Reset
REQ-031 rst_i high at an edge SHALL force state IDLE, en_o=0, ph_o=0, busy_o=0, frame_o=0, frame_cnt_o=0, err_o=0, err_ph_o=0, timer=0, overriding all other inputs including mid-WAIT.

Verification
REQ-032 Full frame: run_i=1, skip=0, each done_i[k] pulsed 3 cycles after en_o[k] rises -> en_o sequence 001,010,100, frame_o one pulse, frame_cnt_o=1, err_o=0.
REQ-033 Timeout: TO_CYC=8, done_i[1] never asserted -> en_o[1] high exactly 8 cycles, err_o=1, err_ph_o=1, display phase then proceeds; err_clr_i pulse -> err_o=0.
REQ-034 Skip: cfg_skip_i=3'b010 -> en_o[1] never high; en_o[2] rises 4 edges after en_o[0] falls.
REQ-035 Wrap and step: 256 frames under run_i -> frame_cnt_o=0; then run_i=0, one step_i pulse -> exactly one frame_o, busy_o returns 0.
REQ-036 Corner: done_i[0] on the timeout edge -> no error; rst_i during WAIT of phase 2 -> all outputs zero next cycle, stray done_i[2] afterwards ignored.
